data_memory_lsu: RTL and testbench

- Parametrised successor to the core's simple data RAM.
- Byte-addressed data memory with independent store and load channels and byte/half/word(/double) access sizes.
- Loads support sign or zero extension, with write-first forwarding on same-cycle address collisions.
- Alignment/size errors are reported on a registered response; the block sits between the execute stage and writeback of the CPU pipeline.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_lane_ram.sv | 27 ++
 rtl/data_memory_lsu.sv | 130 +++++++++++++
 tb/tb_data_memory_lsu.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared size encodings and access-decode helpers for the data memory LSU.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE   = 2'd0;
  localparam logic [1:0] SZ_HALF   = 2'd1;
  localparam logic [1:0] SZ_WORD   = 2'd2;
  localparam logic [1:0] SZ_DOUBLE = 2'd3;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  // Only the low three address bits matter, since no access exceeds 8 bytes.
  function automatic logic is_aligned(input logic [2:0] addr_lo, input logic [1:0] size);
    logic ok;
    unique case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (addr_lo[0] == 1'b0);
      SZ_WORD: ok = (addr_lo[1:0] == 2'b00);
      default: ok = (addr_lo == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// Byte-lane banked RAM: one 8-bit bank per lane, per-lane write enable,
// shared word indices, synchronous read (old data on a same-edge write).
module dmem_lane_ram #(
  parameter int LANES = 4,
  parameter int IDX_W = 10
) (
  input  logic                 clk,
  input  logic [LANES-1:0]     we,
  input  logic [IDX_W-1:0]     waddr,
  input  logic [LANES*8-1:0]   wdata,
  input  logic [IDX_W-1:0]     raddr,
  output logic [LANES*8-1:0]   rdata
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] mem [2**IDX_W];
    logic [7:0] rd_reg;

    always_ff @(posedge clk) begin
      if (we[gi]) mem[waddr] <= wdata[gi*8 +: 8];
      rd_reg <= mem[raddr];
    end

    assign rdata[gi*8 +: 8] = rd_reg;
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Data memory load/store unit: access decode, per-lane store enables,
// write-first forwarding on same-word collisions, load extension, responses.
module data_memory_lsu
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st_valid,
  input  logic [1:0]            st_size,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic                  ld_valid,
  input  logic [1:0]            ld_size,
  input  logic                  ld_signed,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  ld_rsp_valid,
  output logic [DATA_WIDTH-1:0] ld_rsp_data,
  output logic                  ld_rsp_err,
  output logic                  st_err
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFS_W = $clog2(LANES);
  localparam int IDX_W = ADDR_WIDTH - OFS_W;

  logic [OFS_W-1:0]      st_off, ld_off;
  logic [IDX_W-1:0]      st_idx, ld_idx;
  logic                  st_ok, ld_ok;
  logic [LANES-1:0]      st_mask, ram_we;
  logic [DATA_WIDTH-1:0] st_wdata, ram_rdata;

  assign st_off   = st_addr[OFS_W-1:0];
  assign st_idx   = st_addr[ADDR_WIDTH-1:OFS_W];
  assign ld_off   = ld_addr[OFS_W-1:0];
  assign ld_idx   = ld_addr[ADDR_WIDTH-1:OFS_W];
  assign st_ok    = st_valid && (int'(size_bytes(st_size)) <= LANES) && is_aligned(st_addr[2:0], st_size);
  assign ld_ok    = (int'(size_bytes(ld_size)) <= LANES) && is_aligned(ld_addr[2:0], ld_size);
  assign st_wdata = st_data << {st_off, 3'b000};

  always_comb begin
    st_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      st_mask[i] = st_ok && (i >= int'(st_off)) &&
                   (i < int'(st_off) + int'(size_bytes(st_size)));
    end
  end

  // A store seen while reset is held must not land in the array.
  assign ram_we = rst_n ? st_mask : '0;

  dmem_lane_ram #(
    .LANES (LANES),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (st_idx),
    .wdata (st_wdata),
    .raddr (ld_idx),
    .rdata (ram_rdata)
  );

  logic                  rsp_valid_reg, rsp_err_reg, st_err_reg;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic [OFS_W-1:0]      ld_off_reg;
  logic [1:0]            ld_size_reg;
  logic                  ld_signed_reg;
  logic [LANES-1:0]      fwd_mask_reg;
  logic [DATA_WIDTH-1:0] fwd_data_reg;

  // Load-side context travels alongside the synchronous RAM read.
  always_ff @(posedge clk) begin
    if (ld_valid) begin
      ld_off_reg    <= ld_off;
      ld_size_reg   <= ld_size;
      ld_signed_reg <= ld_signed;
      fwd_mask_reg  <= (st_idx == ld_idx) ? st_mask : '0;
      fwd_data_reg  <= st_wdata;
    end
  end

  logic [DATA_WIDTH-1:0] merged, shifted, extended, formed;
  logic                  fill_msb;
  int                    field_bits;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_fwd
    assign merged[gi*8 +: 8] = fwd_mask_reg[gi] ? fwd_data_reg[gi*8 +: 8] : ram_rdata[gi*8 +: 8];
  end

  assign shifted    = merged >> {ld_off_reg, 3'b000};
  assign field_bits = 8 << ld_size_reg;

  always_comb begin
    unique case (ld_size_reg)
      SZ_BYTE: fill_msb = shifted[7];
      SZ_HALF: fill_msb = shifted[15];
      SZ_WORD: fill_msb = shifted[31];
      default: fill_msb = 1'b0;
    endcase
    extended = shifted;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i >= field_bits) extended[i] = ld_signed_reg & fill_msb;
    end
  end

  assign formed = rsp_err_reg ? '0 : extended;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      st_err_reg    <= 1'b0;
      hold_reg      <= '0;
    end else begin
      rsp_valid_reg <= ld_valid;
      rsp_err_reg   <= ld_valid && !ld_ok;
      st_err_reg    <= st_valid && !st_ok;
      if (rsp_valid_reg) hold_reg <= formed;
    end
  end

  assign ld_rsp_valid = rsp_valid_reg;
  assign ld_rsp_err   = rsp_err_reg;
  assign ld_rsp_data  = rsp_valid_reg ? formed : hold_reg;
  assign st_err       = st_err_reg;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu (DATA_WIDTH=32, ADDR_WIDTH=12).
module tb_data_memory_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [1:0]  st_size;
  logic [11:0] st_addr;
  logic [31:0] st_data;
  logic        ld_valid;
  logic [1:0]  ld_size;
  logic        ld_signed;
  logic [11:0] ld_addr;
  logic        ld_rsp_valid;
  logic [31:0] ld_rsp_data;
  logic        ld_rsp_err;
  logic        st_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_memory_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_size      (st_size),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .ld_valid     (ld_valid),
    .ld_size      (ld_size),
    .ld_signed    (ld_signed),
    .ld_addr      (ld_addr),
    .ld_rsp_valid (ld_rsp_valid),
    .ld_rsp_data  (ld_rsp_data),
    .ld_rsp_err   (ld_rsp_err),
    .st_err       (st_err)
  );

  typedef struct {
    logic        st_v;
    logic [1:0]  st_sz;
    logic [11:0] st_a;
    logic [31:0] st_d;
    logic        ld_v;
    logic [1:0]  ld_sz;
    logic        ld_s;
    logic [11:0] ld_a;
    logic        e_v;
    logic [31:0] e_d;
    logic        e_err;
    logic        e_serr;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [1:0] ssz, input logic [11:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [1:0] lsz, input logic ls, input logic [11:0] la);
    st_valid = sv; st_size = ssz; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_size = lsz; ld_signed = ls; ld_addr = la;
  endtask

  task automatic check_all(input string tag, input logic v, input logic [31:0] d, input logic e, input logic se);
    check({tag, ".valid"},  32'(ld_rsp_valid), 32'(v));
    check({tag, ".data"},   ld_rsp_data, d);
    check({tag, ".err"},    32'(ld_rsp_err), 32'(e));
    check({tag, ".st_err"}, 32'(st_err), 32'(se));
  endtask

  logic [31:0] b2b_exp [4];

  initial begin
    //                st_v  sz     addr      data          ld_v  sz     sgn   addr      e_v   e_d           e_err e_serr
    vecs[0]  = '{1'b1, 2'd2, 12'h020, 32'h11223344, 1'b0, 2'd0, 1'b0, 12'h000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2'd2, 12'h010, 32'hDEADBEEF, 1'b0, 2'd0, 1'b0, 12'h000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 12'h000, 32'h00000000, 1'b1, 2'd2, 1'b0, 12'h010, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 12'h000, 32'h00000000, 1'b1, 2'd0, 1'b1, 12'h013, 1'b1, 32'hFFFFFFDE, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 12'h000, 32'h00000000, 1'b1, 2'd0, 1'b0, 12'h013, 1'b1, 32'h000000DE, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 12'h000, 32'h00000000, 1'b1, 2'd1, 1'b1, 12'h010, 1'b1, 32'hFFFFBEEF, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 2'd0, 12'h011, 32'hAAAAAA55, 1'b0, 2'd0, 1'b0, 12'h000, 1'b0, 32'hFFFFBEEF, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 2'd0, 12'h000, 32'h00000000, 1'b1, 2'd2, 1'b0, 12'h010, 1'b1, 32'hDEAD55EF, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 2'd1, 12'h021, 32'h0000FFFF, 1'b0, 2'd0, 1'b0, 12'h000, 1'b0, 32'hDEAD55EF, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 2'd0, 12'h000, 32'h00000000, 1'b1, 2'd2, 1'b0, 12'h020, 1'b1, 32'h11223344, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 2'd0, 12'h000, 32'h00000000, 1'b1, 2'd2, 1'b0, 12'h022, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 2'd0, 12'h000, 32'h00000000, 1'b1, 2'd3, 1'b0, 12'h010, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 2'd3, 12'h018, 32'h99999999, 1'b1, 2'd1, 1'b0, 12'h012, 1'b1, 32'h0000DEAD, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 2'd1, 12'h012, 32'h00001234, 1'b1, 2'd2, 1'b0, 12'h010, 1'b1, 32'h123455EF, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 2'd0, 12'h000, 32'h00000000, 1'b1, 2'd2, 1'b0, 12'h010, 1'b1, 32'h123455EF, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 2'd0, 12'h000, 32'h00000000, 1'b0, 2'd0, 1'b0, 12'h000, 1'b0, 32'h123455EF, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 2'd0, 12'h013, 32'h00000080, 1'b1, 2'd0, 1'b1, 12'h013, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 2'd0, 12'h000, 32'h00000000, 1'b1, 2'd1, 1'b1, 12'h012, 1'b1, 32'hFFFF8034, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 2'd0, 12'h000, 32'h00000000, 1'b1, 2'd1, 1'b1, 12'h020, 1'b1, 32'h00003344, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 2'd0, 12'h0, 32'h0, 1'b0, 2'd0, 1'b0, 12'h0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].st_v, vecs[i].st_sz, vecs[i].st_a, vecs[i].st_d,
            vecs[i].ld_v, vecs[i].ld_sz, vecs[i].ld_s, vecs[i].ld_a);
      @(posedge clk);
      #1;
      $display("vec %0d: st=%b/%0d@%h ld=%b/%0d@%h -> v=%b d=%h err=%b st_err=%b",
               i, vecs[i].st_v, vecs[i].st_sz, vecs[i].st_a, vecs[i].ld_v, vecs[i].ld_sz, vecs[i].ld_a,
               ld_rsp_valid, ld_rsp_data, ld_rsp_err, st_err);
      check_all($sformatf("vec%0d", i), vecs[i].e_v, vecs[i].e_d, vecs[i].e_err, vecs[i].e_serr);
    end

    // Four back-to-back byte loads from the word 0x11223344 at 0x20.
    b2b_exp[0] = 32'h44; b2b_exp[1] = 32'h33; b2b_exp[2] = 32'h22; b2b_exp[3] = 32'h11;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'd0, 12'h0, 32'h0, 1'b1, 2'd0, 1'b0, 12'(12'h020 + k));
      @(posedge clk);
      #1;
      $display("b2b %0d: v=%b d=%h", k, ld_rsp_valid, ld_rsp_data);
      check_all($sformatf("b2b%0d", k), 1'b1, b2b_exp[k], 1'b0, 1'b0);
    end
    drive(1'b0, 2'd0, 12'h0, 32'h0, 1'b0, 2'd0, 1'b0, 12'h0);
    @(posedge clk);
    #1;
    $display("b2b idle: v=%b d=%h", ld_rsp_valid, ld_rsp_data);
    check_all("b2b_idle", 1'b0, 32'h11, 1'b0, 1'b0);

    // Reset in the middle of traffic: outputs clear at once, store is dropped.
    drive(1'b0, 2'd0, 12'h0, 32'h0, 1'b1, 2'd2, 1'b0, 12'h010);
    @(posedge clk);
    #1;
    $display("pre-reset: v=%b d=%h", ld_rsp_valid, ld_rsp_data);
    check_all("pre_rst", 1'b1, 32'h803455EF, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(1'b1, 2'd2, 12'h010, 32'hCAFEF00D, 1'b1, 2'd2, 1'b0, 12'h010);
    #1;
    $display("reset asserted: v=%b d=%h", ld_rsp_valid, ld_rsp_data);
    check_all("rst_async", 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("rst_edge", 1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 12'h0, 32'h0, 1'b1, 2'd2, 1'b0, 12'h010);
    @(posedge clk);
    #1;
    $display("post-reset: v=%b d=%h", ld_rsp_valid, ld_rsp_data);
    check_all("post_rst", 1'b1, 32'h803455EF, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
